// File: rtl/perm_pkg.sv
// Shared types and constants for the SHA-3 padding feeder.
package perm_pkg;

    localparam int LANE_W = 64;
    localparam int NLANES = 25;

    localparam logic [7:0] PAD_DOM = 8'h06;
    localparam logic [7:0] PAD_END = 8'h80;

    typedef logic [LANE_W-1:0] lane_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MSG  = 2'd1,
        PAD  = 2'd2,
        CAP  = 2'd3
    } state_t;

    // Byte-keep mask for a final lane holding n valid bytes (n >= 8 keeps all).
    function automatic lane_t keep_mask(input logic [3:0] n);
        lane_t m;
        if (n[3]) begin
            m = {LANE_W{1'b1}};
        end else begin
            m = ({{(LANE_W-1){1'b0}}, 1'b1} << {n[2:0], 3'b000}) - {{(LANE_W-1){1'b0}}, 1'b1};
        end
        return m;
    endfunction

endpackage

// File: rtl/perm_pad_blk_fmt.sv
// Lane formatter: masks the tail of a final message lane and inserts the
// 0x06 domain byte and the 0x80 end bit. Purely combinational.
import perm_pkg::*;

module pad_lane_fmt (
    input  logic [LANE_W-1:0] din,
    input  logic [3:0]        n,
    input  logic              is_last,
    input  logic              padpend,
    input  logic              is_final_rate_lane,
    output logic [LANE_W-1:0] lane
);

    logic [LANE_W-1:0] body_s;
    logic [LANE_W-1:0] dom_at_n_s;
    logic [LANE_W-1:0] extra_s;

    // Domain byte lands right after the last valid byte when the lane is not full.
    assign dom_at_n_s = (is_last && !n[3])
                      ? ({{(LANE_W-8){1'b0}}, PAD_DOM} << {n[2:0], 3'b000})
                      : {LANE_W{1'b0}};

    assign body_s = is_last ? ((din & keep_mask(n)) | dom_at_n_s) : din;

    // Owed domain byte always sits in byte 0; the end bit in byte 7.
    assign extra_s = {(is_final_rate_lane ? PAD_END : 8'h00),
                      {(LANE_W-16){1'b0}},
                      (padpend ? PAD_DOM : 8'h00)};

    assign lane = body_s | extra_s;

endmodule

// File: rtl/perm_pad_blk.sv
// SHA-3 padding feeder: turns a lane stream into complete 25-lane blocks
// (rate lanes then zero capacity lanes) behind a single output register.
import perm_pkg::*;

module perm_pad_blk #(
    parameter int RATE_LANES = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pushin,
    output logic              stopin,
    input  logic              firstin,
    input  logic              lastin,
    input  logic [3:0]        nbytesin,
    input  logic [LANE_W-1:0] din,
    output logic              pushout,
    input  logic              stopout,
    output logic              firstout,
    output logic [LANE_W-1:0] dout
);

    localparam logic [4:0] LI_LAST_RATE = 5'(RATE_LANES - 1);
    localparam logic [4:0] LI_MAX       = 5'(NLANES - 1);

    state_t            state_r, state_n;
    logic [4:0]        li_r, li_n;
    logic              done_r, done_n;
    logic              padpend_r, padpend_n;
    logic              pushout_r, firstout_r;
    lane_t             dout_r;

    logic              load_s, accept_s, msg_lane_s, final_rate_s, emit_s;
    logic              fmt_last_s, fmt_pad_s, fmt_final_s;
    lane_t             fmt_din_s, fmt_lane_s, lane_s;

    assign load_s       = !pushout_r || !stopout;
    assign stopin       = ((state_r != IDLE) && (state_r != MSG)) || (pushout_r && stopout);
    assign accept_s     = pushin && !stopin;
    assign final_rate_s = (li_r == LI_LAST_RATE);
    assign msg_lane_s   = accept_s && ((state_r == MSG) || ((state_r == IDLE) && firstin));

    // Self-generated pad lanes start from zero and never carry a masked tail.
    assign fmt_din_s   = (state_r == PAD) ? {LANE_W{1'b0}} : din;
    assign fmt_last_s  = (state_r != PAD) && lastin;
    assign fmt_pad_s   = (state_r == PAD) && padpend_r;
    assign fmt_final_s = final_rate_s && ((state_r == PAD) || (lastin && !nbytesin[3]));

    pad_lane_fmt u_fmt (
        .din                (fmt_din_s),
        .n                  (nbytesin),
        .is_last            (fmt_last_s),
        .padpend            (fmt_pad_s),
        .is_final_rate_lane (fmt_final_s),
        .lane               (fmt_lane_s)
    );

    // Next-state, lane index, flags and the lane offered to the output register.
    always_comb begin
        state_n   = state_r;
        li_n      = li_r;
        done_n    = done_r;
        padpend_n = padpend_r;
        emit_s    = 1'b0;
        lane_s    = {LANE_W{1'b0}};
        case (state_r)
            IDLE, MSG: begin
                if (msg_lane_s) begin
                    emit_s = 1'b1;
                    lane_s = fmt_lane_s;
                    li_n   = li_r + 5'd1;
                    if (lastin) begin
                        done_n    = 1'b1;
                        padpend_n = nbytesin[3];
                    end else begin
                        done_n    = 1'b0;
                        padpend_n = 1'b0;
                    end
                    if (final_rate_s) begin
                        state_n = CAP;
                    end else if (lastin) begin
                        state_n = PAD;
                    end else begin
                        state_n = MSG;
                    end
                end else begin
                    state_n = state_r;
                end
            end
            PAD: begin
                if (load_s) begin
                    emit_s    = 1'b1;
                    lane_s    = fmt_lane_s;
                    padpend_n = 1'b0;
                    li_n      = li_r + 5'd1;
                    state_n   = final_rate_s ? CAP : PAD;
                end else begin
                    state_n = state_r;
                end
            end
            CAP: begin
                if (load_s) begin
                    emit_s = 1'b1;
                    lane_s = {LANE_W{1'b0}};
                    if (li_r == LI_MAX) begin
                        li_n = 5'd0;
                        if (padpend_r) begin
                            state_n = PAD;
                        end else if (done_r) begin
                            state_n = IDLE;
                        end else begin
                            state_n = MSG;
                        end
                    end else begin
                        li_n = li_r + 5'd1;
                    end
                end else begin
                    state_n = state_r;
                end
            end
            default: begin
                state_n   = IDLE;
                li_n      = 5'd0;
                done_n    = 1'b0;
                padpend_n = 1'b0;
            end
        endcase
    end

    // Control state: FSM, lane index and padding flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            li_r      <= 5'd0;
            done_r    <= 1'b0;
            padpend_r <= 1'b0;
        end else begin
            state_r   <= state_n;
            li_r      <= li_n;
            done_r    <= done_n;
            padpend_r <= padpend_n;
        end
    end

    // Output register: loads when empty or draining, holds steady under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            pushout_r  <= 1'b0;
            firstout_r <= 1'b0;
            dout_r     <= {LANE_W{1'b0}};
        end else if (load_s) begin
            pushout_r  <= emit_s;
            firstout_r <= emit_s && (li_r == 5'd0);
            dout_r     <= lane_s;
        end else begin
            pushout_r  <= pushout_r;
            firstout_r <= firstout_r;
            dout_r     <= dout_r;
        end
    end

    assign pushout  = pushout_r;
    assign firstout = firstout_r;
    assign dout     = dout_r;

endmodule

// File: tb/tb_perm_pad_blk.sv
// Bench for perm_pad_blk: byte-level SHA-3 padding model, randomized traffic
// and stalls, directed padding corner cases and a mid-block reset.
module tb_perm_pad_blk;
    import perm_pkg::*;

    localparam int R = 17;

    logic        clk, rst, pushin, firstin, lastin, stopout;
    logic [3:0]  nbytesin;
    logic [63:0] din;
    logic        stopin, pushout, firstout;
    logic [63:0] dout;

    int          n_cmp, n_err;
    logic [63:0] exp_lane[$];
    logic        exp_first[$];
    logic [7:0]  msg_b[0:511];
    bit          chk_en, rnd_stall, force_stall, gap_en;
    int          base;

    perm_pad_blk #(.RATE_LANES(R)) dut (
        .clk(clk), .rst(rst), .pushin(pushin), .stopin(stopin),
        .firstin(firstin), .lastin(lastin), .nbytesin(nbytesin), .din(din),
        .pushout(pushout), .stopout(stopout), .firstout(firstout), .dout(dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Downstream stall generator
    initial begin
        stopout = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (force_stall) stopout = 1'b1;
            else if (rnd_stall) stopout = ($urandom_range(0, 3) == 0);
            else stopout = 1'b0;
        end
    end

    // Reference: pad message bytes to whole rate blocks (0x06 after the data,
    // 0x80 in the last rate byte), then append zero capacity lanes per block.
    task automatic model_msg(input int len);
        int nblk, tot, idx;
        logic [63:0] w;
        logic [7:0] v;
        nblk = len / (R * 8) + 1;
        tot  = nblk * R * 8;
        for (int b = 0; b < nblk; b++) begin
            for (int l = 0; l < NLANES; l++) begin
                w = 64'h0;
                if (l < R) begin
                    for (int k = 0; k < 8; k++) begin
                        idx = (b * R + l) * 8 + k;
                        v = (idx < len) ? msg_b[idx] : 8'h00;
                        if (idx == len) v = v | 8'h06;
                        if (idx == tot - 1) v = v | 8'h80;
                        w[8*k +: 8] = v;
                    end
                end
                exp_lane.push_back(w);
                exp_first.push_back(l == 0);
            end
        end
    endtask

    task automatic fill_rand(input int len);
        for (int i = 0; i < len; i++) msg_b[i] = 8'($urandom);
    endtask

    task automatic send_lane(input logic [63:0] d, input logic f, input logic l, input logic [3:0] n);
        bit acc;
        int t;
        if (gap_en && ($urandom_range(0, 3) == 0)) begin
            pushin = 1'b0;
            @(posedge clk); #1;
        end
        pushin = 1'b1; din = d; firstin = f; lastin = l; nbytesin = n;
        acc = 1'b0;
        t = 0;
        while (!acc && t < 500) begin
            @(negedge clk);
            acc = !stopin;
            @(posedge clk); #1;
            t++;
        end
        pushin = 1'b0; firstin = 1'b0; lastin = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: lane not accepted after %0d cycles, required acceptance", t);
        end
    endtask

    task automatic build_lane(input int len, input int i, output logic [63:0] d);
        for (int k = 0; k < 8; k++)
            d[8*k +: 8] = ((8 * i + k) < len) ? msg_b[8 * i + k] : 8'($urandom);
    endtask

    task automatic send_msg(input int len);
        int nl;
        logic [63:0] d;
        logic [3:0] n;
        logic f;
        if (gap_en)
            repeat ($urandom_range(0, 2))
                send_lane({$urandom, $urandom}, 1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 8)));
        nl = (len == 0) ? 1 : (len + 7) / 8;
        for (int i = 0; i < nl; i++) begin
            build_lane(len, i, d);
            f = (i == 0) ? 1'b1 : 1'($urandom_range(0, 7) == 0);
            n = (i == nl - 1) ? 4'(len - 8 * i) : 4'($urandom_range(0, 15));
            send_lane(d, f, (i == nl - 1), n);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_lane.size() != 0 && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_leftover_lanes", 64'(exp_lane.size()), 64'd0);
    endtask

    // Output checker: every transferred lane against the model, plus hold under stall
    initial begin
        logic [63:0] e, p_dout;
        logic ef, p_first, hold_prev;
        hold_prev = 1'b0;
        p_dout = 64'h0;
        p_first = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (hold_prev) begin
                    check("hold_pushout", {63'h0, pushout}, 64'd1);
                    check("hold_dout", dout, p_dout);
                    check("hold_firstout", {63'h0, firstout}, {63'h0, p_first});
                end
                if (pushout && !stopout) begin
                    if (exp_lane.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL extra_lane: got %h expected no lane", dout);
                    end else begin
                        e  = exp_lane.pop_front();
                        ef = exp_first.pop_front();
                        check("dout", dout, e);
                        check("firstout", {63'h0, firstout}, {63'h0, ef});
                    end
                end
                hold_prev = pushout && stopout;
                p_dout = dout;
                p_first = firstout;
            end else begin
                hold_prev = 1'b0;
            end
        end
    end

    initial begin
        logic [63:0] d;
        n_cmp = 0; n_err = 0;
        chk_en = 1'b0; rnd_stall = 1'b0; force_stall = 1'b0; gap_en = 1'b0;
        rst = 1'b1; pushin = 1'b0; firstin = 1'b0; lastin = 1'b0;
        nbytesin = 4'd0; din = 64'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_pushout", {63'h0, pushout}, 64'd0);
        check("reset_firstout", {63'h0, firstout}, 64'd0);
        check("reset_dout", dout, 64'd0);
        check("reset_stopin", {63'h0, stopin}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // Empty message
        base = exp_lane.size();
        model_msg(0);
        check("model_empty_count", 64'(exp_lane.size() - base), 64'd25);
        check("model_empty_lane0", exp_lane[base], 64'h06);
        check("model_empty_lane16", exp_lane[base + 16], 64'h8000000000000000);
        send_msg(0);

        // "abc"
        msg_b[0] = 8'h61; msg_b[1] = 8'h62; msg_b[2] = 8'h63;
        base = exp_lane.size();
        model_msg(3);
        check("model_abc_lane0", exp_lane[base], 64'h0000000006636261);
        send_msg(3);

        // 136 bytes: full rate block, padding spills into a second block
        fill_rand(136);
        base = exp_lane.size();
        model_msg(136);
        check("model_136_count", 64'(exp_lane.size() - base), 64'd50);
        check("model_136_lane25", exp_lane[base + 25], 64'h06);
        check("model_136_lane41", exp_lane[base + 41], 64'h8000000000000000);
        send_msg(136);

        // 135 bytes: domain and end bit share byte 7 of lane 16
        fill_rand(128);
        d = 64'h00AABBCCDDEEFF11;
        for (int k = 0; k < 7; k++) msg_b[128 + k] = d[8*k +: 8];
        base = exp_lane.size();
        model_msg(135);
        check("model_135_count", 64'(exp_lane.size() - base), 64'd25);
        check("model_135_lane16", exp_lane[base + 16], 64'h86AABBCCDDEEFF11);
        send_msg(135);
        drain();

        // Five-cycle downstream stall in the middle of a block
        fill_rand(100);
        model_msg(100);
        fork
            send_msg(100);
            begin
                repeat (6) @(posedge clk);
                force_stall = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_stopin", {63'h0, stopin}, 64'd1);
                end
                force_stall = 1'b0;
            end
        join
        drain();

        // Reset right after lane 10 of a block is accepted
        fill_rand(200);
        model_msg(200);
        for (int i = 0; i < 11; i++) begin
            build_lane(200, i, d);
            send_lane(d, (i == 0), 1'b0, 4'd8);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("post_rst_pushout", {63'h0, pushout}, 64'd0);
        check("post_rst_stopin", {63'h0, stopin}, 64'd0);
        exp_lane.delete();
        exp_first.delete();
        msg_b[0] = 8'h61; msg_b[1] = 8'h62; msg_b[2] = 8'h63;
        model_msg(3);
        send_msg(3);
        drain();

        // Randomized messages with random gaps, junk idle lanes and stalls
        rnd_stall = 1'b1;
        gap_en = 1'b1;
        for (int m = 0; m < 25; m++) begin
            int len;
            len = $urandom_range(0, 300);
            fill_rand(len);
            model_msg(len);
            send_msg(len);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/perm_pad_blk.md
Name: perm_pad_blk

Overview:
Upstream feeder of the Keccak permutation stage. Takes a message as a stream of 64-bit little-endian lanes and applies SHA-3 padding (0x06 domain byte, final 0x80 bit). Emits complete 25-lane blocks, one lane per cycle: RATE_LANES message/pad lanes followed by zero capacity lanes, in the pushin/stopin/firstin/din order the permutation block consumes. The absorb XOR with the running state is done downstream, not here.

Parameters:
RATE_LANES, 17, rate in 64-bit lanes (17 = SHA3-256); legal range 1..24
NLANES, 25, lanes per Keccak state (fixed, from the package)

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
pushin  input  1  input lane valid
stopin  output  1  input stall; a lane transfers when pushin && !stopin
firstin  input  1  marks the first lane of a message
lastin  input  1  marks the last lane of a message
nbytesin  input  4  valid bytes in the last lane, 0..8; ignored unless lastin
din  input  64  message lane; byte i at bits [8i+7:8i]
pushout  output  1  output lane valid
stopout  input  1  downstream stall; a lane transfers when pushout && !stopout
firstout  output  1  asserted with lane 0 of every emitted block
dout  output  64  padded lane

Behaviour:
- Reset: on rst at a clk edge, outputs go to pushout=0, firstout=0, dout=0, stopin=0. Lane index is cleared, flags are cleared, state goes to IDLE. A partial block in flight is discarded with no further output.
- Output register: one stage. An accepted or generated lane appears on dout exactly 1 cycle later. The register loads only when it is empty or draining (!pushout || !stopout). While pushout && stopout, dout and firstout hold stable.
- stopin (combinational) = (state not IDLE/MSG) || (pushout && stopout).
- Lane index li counts 0..24 and wraps to 0 after 24. firstout = (li==0) for the emitted lane.
- Flags:
  - done: last message lane has been seen.
  - padpend: the 0x06 byte is still owed.
- IDLE:
  - lanes without firstin are accepted and dropped, with no output.
  - a lane with firstin is processed as a MSG lane.
- MSG (li < RATE_LANES), per accepted lane:
  - Not last: emit din. If li==RATE_LANES-1, go to CAP; else stay.
  - Last, nbytesin = n < 8: emit din with bytes >= n zeroed and byte n = 0x06. If li==RATE_LANES-1, byte 7 |= 0x80 (n=7 gives byte 7 = 0x86). Set done. Go to CAP if li==RATE_LANES-1, else PAD.
  - Last, n = 8: emit din unmodified. Set done and padpend. Go to CAP if li==RATE_LANES-1, else PAD.
  - firstin on a non-IDLE lane is ignored; the lane is treated as ordinary.
- PAD:
  - Self-generated lanes, one per cycle whenever the output register can load.
  - Lane value is 0. If padpend: byte 0 = 0x06 and padpend is cleared. If li==RATE_LANES-1: byte 7 |= 0x80.
  - After li==RATE_LANES-1, go to CAP.
- CAP:
  - Emit zero lanes for li = RATE_LANES..24.
  - After li==24: go to IDLE if done && !padpend; go to PAD if padpend (a new block starting with 0x06 at lane 0); else go to MSG.
- Throughput: 1 lane/cycle with no stall. Output is exactly 25 lanes per block, and every message produces at least one block.
- Simultaneous events: the output register loading in the same cycle as downstream acceptance is legal and gives back-to-back lanes. rst has priority over everything.

Decomposition:
- Package perm_pkg holds:
  - LANE_W=64 and NLANES=25
  - PAD_DOM=8'h06 and PAD_END=8'h80
  - the state enum {IDLE, MSG, PAD, CAP}
  - a lane_t typedef
- One natural combinational sub-module, pad_lane_fmt. Inputs: din, n, is_last, padpend, is_final_rate_lane. Output: the formatted lane (byte masking plus 0x06/0x80 insertion). The FSM, counters and output register stay in perm_pad_blk.

Test Plan:
- Empty message, RATE_LANES=17 (firstin, lastin, nbytesin=0) -> 25 lanes: lane0=64'h06, lanes1-15=0, lane16=64'h8000000000000000, lanes17-24=0; firstout only on lane0.
- "abc" (din=64'h636261, nbytesin=3) -> lane0=64'h0000000006636261, lane16=64'h8000000000000000, all other lanes 0.
- 136-byte message (17 full lanes, last nbytesin=8) -> block 1 = 17 data lanes + 8 zero lanes; block 2 lane0=64'h06, lane16=64'h8000000000000000; 50 lanes total, firstout twice.
- 135-byte message (lane16 last, nbytesin=7, din=64'h00AABBCCDDEEFF11) -> lane16=64'h86AABBCCDDEEFF11; exactly 25 lanes.
- stopout high for 5 cycles mid-block -> dout/firstout/pushout stable, stopin=1, no lane lost or duplicated, order intact after release.
- rst for 1 cycle at lane 10 of a block -> next cycle pushout=0, stopin=0; new message starts a fresh block at li=0 with firstout.
